pipe_stage_reg: RTL and testbench

Parametrised inter-stage pipeline register with a valid/ready handshake. It is the successor to the fixed MA→WB latch and is intended to replace every IF/ID/EX/MA/WB boundary register in the 5-stage RV32 core. It carries a 32-bit instruction word plus a generic payload bus (PC, write-back data, branch flags, …), and supports:
- stall via backpressure;
- flush with NOP injection;
- an optional skid entry, so `in_ready` is a registered signal at full throughput.

---
 rtl/rv_pipe_pkg.sv | 39 +++
 rtl/pipe_entry.sv | 55 +++++
 rtl/pipe_stage_reg.sv | 115 +++++++++++
 tb/tb_pipe_stage_reg.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : rv_pipe_pkg
//  Purpose  : Shared constants for the RV32 inter-stage pipeline registers.
//             Holds the NOP encoding and the payload field layout so every
//             stage packs and unpacks the payload bus identically.
//  Contents : INST_W, NOP_INST, PC_W, WBDATA_W, BR_FLAGS_W, field offsets,
//             PAYLOAD_W and pack_payload().
//  Revision : 1.0 - initial release
// ============================================================================
package rv_pipe_pkg;

   localparam int INST_W     = 32;
   // addi x0,x0,0
   localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0013;

   localparam int PC_W       = 32;
   localparam int WBDATA_W   = 32;
   localparam int BR_FLAGS_W = 3;

   // Payload layout, LSB first: PC, write-back data, branch flags.
   localparam int PC_LSB         = 0;
   localparam int WBDATA_LSB     = PC_LSB + PC_W;
   localparam int BR_TAKEN_BIT   = WBDATA_LSB + WBDATA_W;
   localparam int BR_MISPRED_BIT = BR_TAKEN_BIT + 1;
   localparam int BR_VALID_BIT   = BR_TAKEN_BIT + 2;

   localparam int PAYLOAD_W = PC_W + WBDATA_W + BR_FLAGS_W;

   function automatic logic [PAYLOAD_W-1:0] pack_payload(
      input logic [PC_W-1:0]       pc,
      input logic [WBDATA_W-1:0]   wbdata,
      input logic [BR_FLAGS_W-1:0] br_flags
   );
      return {br_flags, wbdata, pc};
   endfunction

endpackage : rv_pipe_pkg
`default_nettype wire

// File: rtl/pipe_entry.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_entry
//  Purpose  : One pipeline slot: valid flag + instruction + payload register
//             with clear (highest priority) and load controls. A cleared or
//             reset slot holds NOP_INST / zero payload so its outputs are
//             always safe to present downstream.
//  Ports    : clk, reset (async, active-high), clear, load,
//             load_inst, load_payload  -> data captured on load
//             valid, inst, payload     -> registered slot contents
//  Revision : 1.0 - initial release
// ============================================================================
module pipe_entry
   import rv_pipe_pkg::*;
#(
   parameter int                PAYLOAD_W = 67,
   parameter logic [INST_W-1:0] NOP_INST  = rv_pipe_pkg::NOP_INST
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 clear,
   input  logic                 load,
   input  logic [INST_W-1:0]    load_inst,
   input  logic [PAYLOAD_W-1:0] load_payload,
   output logic                 valid,
   output logic [INST_W-1:0]    inst,
   output logic [PAYLOAD_W-1:0] payload
);

   logic                 r_valid;
   logic [INST_W-1:0]    r_inst;
   logic [PAYLOAD_W-1:0] r_payload;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_valid   <= 1'b0;
         r_inst    <= NOP_INST;
         r_payload <= '0;
      end else if (clear) begin
         r_valid   <= 1'b0;
         r_inst    <= NOP_INST;
         r_payload <= '0;
      end else if (load) begin
         r_valid   <= 1'b1;
         r_inst    <= load_inst;
         r_payload <= load_payload;
      end
   end

   assign valid   = r_valid;
   assign inst    = r_inst;
   assign payload = r_payload;

endmodule : pipe_entry
`default_nettype wire

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_stage_reg
//  Purpose  : Inter-stage pipeline register with valid/ready handshake,
//             flush with NOP injection and an optional skid entry that makes
//             in_ready a pure register output at full throughput.
//  Ports    : clk, reset (async, active-high), flush (sync kill)
//             in_valid/in_ready/in_inst/in_payload     - upstream side
//             out_valid/out_ready/out_inst/out_payload - downstream side
//             occupancy - number of held entries (0..2)
//  Revision : 1.0 - initial release
// ============================================================================
module pipe_stage_reg
   import rv_pipe_pkg::*;
#(
   parameter int                PAYLOAD_W = 67,
   parameter int                SKID      = 1,
   parameter logic [INST_W-1:0] NOP_INST  = rv_pipe_pkg::NOP_INST
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 flush,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [INST_W-1:0]    in_inst,
   input  logic [PAYLOAD_W-1:0] in_payload,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [INST_W-1:0]    out_inst,
   output logic [PAYLOAD_W-1:0] out_payload,
   output logic [1:0]           occupancy
);

   logic                 w_m_valid;
   logic [INST_W-1:0]    w_m_inst;
   logic [PAYLOAD_W-1:0] w_m_payload;
   logic                 w_s_valid;
   logic [INST_W-1:0]    w_s_inst;
   logic [PAYLOAD_W-1:0] w_s_payload;

   logic                 w_in_xfer;
   logic                 w_out_xfer;
   logic                 w_m_load;
   logic                 w_m_clear;
   logic [INST_W-1:0]    w_m_src_inst;
   logic [PAYLOAD_W-1:0] w_m_src_payload;

   assign w_in_xfer  = in_valid && in_ready;
   assign w_out_xfer = w_m_valid && out_ready;

   // Main reloads when it is (or is becoming) free and an entry arrives, or
   // when the skid drains into it. While the skid is full in_ready is low,
   // so the skid is the only possible source in that case.
   assign w_m_load        = (w_in_xfer && (!w_m_valid || w_out_xfer)) ||
                            (w_s_valid && w_out_xfer);
   assign w_m_clear       = flush || (w_out_xfer && !w_in_xfer && !w_s_valid);
   assign w_m_src_inst    = w_s_valid ? w_s_inst    : in_inst;
   assign w_m_src_payload = w_s_valid ? w_s_payload : in_payload;

   pipe_entry #(
      .PAYLOAD_W (PAYLOAD_W),
      .NOP_INST  (NOP_INST)
   ) u_main (
      .clk          (clk),
      .reset        (reset),
      .clear        (w_m_clear),
      .load         (w_m_load),
      .load_inst    (w_m_src_inst),
      .load_payload (w_m_src_payload),
      .valid        (w_m_valid),
      .inst         (w_m_inst),
      .payload      (w_m_payload)
   );

   generate
      if (SKID != 0) begin : g_skid
         logic w_s_load;
         logic w_s_clear;

         // The skid only catches an entry arriving while main is held.
         assign w_s_load  = w_in_xfer && w_m_valid && !w_out_xfer;
         assign w_s_clear = flush || (w_s_valid && w_out_xfer);

         pipe_entry #(
            .PAYLOAD_W (PAYLOAD_W),
            .NOP_INST  (NOP_INST)
         ) u_skid (
            .clk          (clk),
            .reset        (reset),
            .clear        (w_s_clear),
            .load         (w_s_load),
            .load_inst    (in_inst),
            .load_payload (in_payload),
            .valid        (w_s_valid),
            .inst         (w_s_inst),
            .payload      (w_s_payload)
         );

         // Registered: depends only on the skid flop.
         assign in_ready = !w_s_valid;
      end else begin : g_no_skid
         assign w_s_valid   = 1'b0;
         assign w_s_inst    = NOP_INST;
         assign w_s_payload = '0;
         assign in_ready    = !w_m_valid || out_ready;
      end
   endgenerate

   assign out_valid   = w_m_valid;
   assign out_inst    = w_m_inst;
   assign out_payload = w_m_payload;
   assign occupancy   = {1'b0, w_m_valid} + {1'b0, w_s_valid};

endmodule : pipe_stage_reg
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipe_stage_reg
//  Purpose  : Self-checking bench for pipe_stage_reg. Two instances (SKID=1
//             and SKID=0) share clock, reset and flush. Accepted inputs are
//             queued per instance; a monitor pops and compares each emitted
//             entry and checks occupancy/in_ready every cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_reg;

   localparam int          PW  = 67;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic clk = 1'b0;
   logic reset, flush;

   logic          iv1, ir1, ov1, or1;
   logic [31:0]   ii1, oi1;
   logic [PW-1:0] ip1, op1;
   logic [1:0]    occ1;

   logic          iv0, ir0, ov0, or0;
   logic [31:0]   ii0, oi0;
   logic [PW-1:0] ip0, op0;
   logic [1:0]    occ0;

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] q1[$];
   logic [31:0] q0[$];

   always #5 clk = ~clk;

   pipe_stage_reg #(.PAYLOAD_W(PW), .SKID(1), .NOP_INST(NOP)) dut1 (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(iv1), .in_ready(ir1), .in_inst(ii1), .in_payload(ip1),
      .out_valid(ov1), .out_ready(or1), .out_inst(oi1), .out_payload(op1),
      .occupancy(occ1));

   pipe_stage_reg #(.PAYLOAD_W(PW), .SKID(0), .NOP_INST(NOP)) dut0 (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(iv0), .in_ready(ir0), .in_inst(ii0), .in_payload(ip0),
      .out_valid(ov0), .out_ready(or0), .out_inst(oi0), .out_payload(op0),
      .occupancy(occ0));

   function automatic logic [PW-1:0] mkpay(input logic [31:0] inst);
      return {inst[2:0], ~inst, inst ^ 32'hA5A5_0000};
   endfunction

   assign ip1 = mkpay(ii1);
   assign ip0 = mkpay(ii0);

   task automatic chk(input string name, input logic [PW-1:0] act,
                      input logic [PW-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- monitors (sample at negedge, inputs move at posedge+1)
   always @(negedge clk) begin
      logic [31:0] e;
      if (reset) begin
         q1.delete();
         chk("rst_occ1", 67'(occ1), 67'd0);
      end else begin
         chk("occ1_vs_queue", 67'(occ1), 67'(q1.size()));
         chk("occ1_max", 67'(occ1 <= 2'd2), 67'd1);
         chk("ready1", 67'(ir1), 67'(occ1 != 2'd2));
         if (!ov1) begin
            chk("idle_inst1", 67'(oi1), 67'(NOP));
            chk("idle_pay1", op1, '0);
         end
         if (ov1 && or1) begin
            if (q1.size() == 0) chk("dup1", 67'(oi1), 67'(NOP) ^ 67'd1);
            else begin
               e = q1.pop_front();
               chk("out_inst1", 67'(oi1), 67'(e));
               chk("out_pay1", op1, mkpay(e));
            end
         end
         if (flush) q1.delete();
         else if (iv1 && ir1) q1.push_back(ii1);
      end
   end

   always @(negedge clk) begin
      logic [31:0] e;
      if (reset) begin
         q0.delete();
         chk("rst_occ0", 67'(occ0), 67'd0);
      end else begin
         chk("occ0_vs_queue", 67'(occ0), 67'(q0.size()));
         chk("occ0_max", 67'(occ0 <= 2'd1), 67'd1);
         chk("ready0", 67'(ir0), 67'(occ0 == 2'd0 || or0));
         if (!ov0) begin
            chk("idle_inst0", 67'(oi0), 67'(NOP));
            chk("idle_pay0", op0, '0);
         end
         if (ov0 && or0) begin
            if (q0.size() == 0) chk("dup0", 67'(oi0), 67'(NOP) ^ 67'd1);
            else begin
               e = q0.pop_front();
               chk("out_inst0", 67'(oi0), 67'(e));
               chk("out_pay0", op0, mkpay(e));
            end
         end
         if (flush) q0.delete();
         else if (iv0 && ir0) q0.push_back(ii0);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic reset_checks(input string tag);
      chk({tag, "_ready1"}, 67'(ir1), 67'd1);
      chk({tag, "_valid1"}, 67'(ov1), 67'd0);
      chk({tag, "_inst1"},  67'(oi1), 67'h13);
      chk({tag, "_pay1"},   op1, '0);
      chk({tag, "_occ1"},   67'(occ1), 67'd0);
      chk({tag, "_ready0"}, 67'(ir0), 67'd1);
      chk({tag, "_valid0"}, 67'(ov0), 67'd0);
      chk({tag, "_inst0"},  67'(oi0), 67'h13);
   endtask

   initial begin
      reset = 1'b1; flush = 1'b0;
      iv1 = 0; ii1 = '0; or1 = 1;
      iv0 = 0; ii0 = '0; or0 = 1;
      #2;
      reset_checks("por");
      repeat (2) step();
      reset = 1'b0;
      step();

      // ---- streaming 0x100..0x10F, both modes, no gaps
      for (int i = 0; i < 16; i++) begin
         iv1 = 1; ii1 = 32'h100 + i;
         iv0 = 1; ii0 = 32'h100 + i;
         @(negedge clk);
         chk("stream_ready1", 67'(ir1), 67'd1);
         chk("stream_ready0", 67'(ir0), 67'd1);
         if (i > 0) begin
            chk("stream_valid1", 67'(ov1), 67'd1);
            chk("stream_head1", 67'(oi1), 67'(32'h100 + i - 1));
            chk("stream_head0", 67'(oi0), 67'(32'h100 + i - 1));
         end
         step();
      end
      iv1 = 0; iv0 = 0;
      repeat (2) step();

      // ---- backpressure on SKID=1: A, B accepted, C held
      or1 = 0;
      iv1 = 1; ii1 = 32'hA; step();
      ii1 = 32'hB; step();
      ii1 = 32'hC; step();
      @(negedge clk);
      chk("bp_ready", 67'(ir1), 67'd0);
      chk("bp_occ", 67'(occ1), 67'd2);
      chk("bp_head", 67'(oi1), 67'hA);
      step();
      or1 = 1;
      @(negedge clk);
      chk("rel_head_a", 67'(oi1), 67'hA);
      chk("rel_ready_a", 67'(ir1), 67'd0);
      step();
      @(negedge clk);
      chk("rel_head_b", 67'(oi1), 67'hB);
      chk("rel_ready_b", 67'(ir1), 67'd1);
      step();
      iv1 = 0;
      @(negedge clk);
      chk("rel_head_c", 67'(oi1), 67'hC);
      repeat (2) step();

      // ---- SKID=0 stall with combinational in_ready
      or0 = 0; iv0 = 1; ii0 = 32'h50;
      step();
      @(negedge clk);
      chk("s0_stall_ready", 67'(ir0), 67'd0);
      chk("s0_stall_valid", 67'(ov0), 67'd1);
      or0 = 1; ii0 = 32'h51;
      #1;
      chk("s0_comb_ready", 67'(ir0), 67'd1);
      step();
      iv0 = 0;
      @(negedge clk);
      chk("s0_replaced", 67'(oi0), 67'h51);
      repeat (2) step();

      // ---- flush with both entries full and input offered
      or1 = 0; iv1 = 1; ii1 = 32'h60; step();
      ii1 = 32'h61; step();
      flush = 1; ii1 = 32'hDEAD; step();
      flush = 0; iv1 = 0;
      @(negedge clk);
      chk("fl2_occ", 67'(occ1), 67'd0);
      chk("fl2_inst", 67'(oi1), 67'h13);
      chk("fl2_ready", 67'(ir1), 67'd1);
      // flush with one entry and in_ready high: 0xDEAD must be dropped
      iv1 = 1; ii1 = 32'h62; step();
      flush = 1; ii1 = 32'hDEAD; step();
      flush = 0; iv1 = 0;
      @(negedge clk);
      chk("fl1_occ", 67'(occ1), 67'd0);
      chk("fl1_valid", 67'(ov1), 67'd0);
      or1 = 1;
      repeat (3) step();

      // ---- asynchronous reset mid-stream with two entries held
      or1 = 0; iv1 = 1; ii1 = 32'h70; step();
      ii1 = 32'h71; step();
      @(negedge clk);
      #2 reset = 1'b1;
      #1;
      reset_checks("midrst");
      iv1 = 0; or1 = 1;
      step(); step();
      reset = 1'b0;
      step();

      // ---- randomised valid/ready, both modes
      for (int c = 0; c < 10000; c++) begin
         iv1 = ($urandom_range(0, 3) != 0); ii1 = 32'h1_0000 + c;
         or1 = ($urandom_range(0, 2) != 0);
         iv0 = ($urandom_range(0, 3) != 0); ii0 = 32'h2_0000 + c;
         or0 = ($urandom_range(0, 2) != 0);
         flush = ($urandom_range(0, 299) == 0);
         step();
      end
      iv1 = 0; iv0 = 0; or1 = 1; or0 = 1; flush = 0;
      repeat (4) step();
      @(negedge clk);
      chk("drain_q1", 67'(q1.size()), 67'd0);
      chk("drain_q0", 67'(q0.size()), 67'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_pipe_stage_reg
`default_nettype wire
